// File: rtl/attack_resolver_if.sv
// Attack resolver port bundle: game control and shot inputs toward the resolver,
// shot results and board-mark maps back out toward the status decoder and LED scanner.
interface attack_resolver_if;
  logic        map_load;
  logic [34:0] map_in;
  logic        confirm;
  logic [2:0]  row;
  logic [2:0]  col;
  logic [1:0]  status;
  logic        result_valid;
  logic [5:0]  hits;
  logic [4:0]  shots;
  logic [5:0]  ship_cells;
  logic [34:0] shot_map;
  logic [34:0] hit_map;
  logic        busy;
  logic        game_over;
  logic        win;

  modport master (
    output map_load, map_in, confirm, row, col,
    input  status, result_valid, hits, shots, ship_cells,
           shot_map, hit_map, busy, game_over, win
  );

  modport slave (
    input  map_load, map_in, confirm, row, col,
    output status, result_valid, hits, shots, ship_cells,
           shot_map, hit_map, busy, game_over, win
  );
endinterface

// File: rtl/attack_resolver.sv
// Battleship shot resolver: edge-detects fire, classifies shots against a 5x7 ship map, tracks hits/shots.
// Optional ATTACK_SHOT_LIMIT_EN ends the game after MAX_SHOTS accepted shots.
module attack_resolver #(
  parameter int MAX_SHOTS = 20
) (
  input logic              clk,
  input logic              rst,
  attack_resolver_if.slave bus
);

  if (MAX_SHOTS < 1 || MAX_SHOTS > 31) begin : g_bad_max_shots
    $error("attack_resolver: MAX_SHOTS must be in 1..31");
  end

  typedef enum logic [2:0] {S_EMPTY, S_READY, S_CHECK, S_UPDATE, S_OVER} state_t;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_MISS = 2'b01;
  localparam logic [1:0] ST_HIT  = 2'b10;
  localparam logic [1:0] ST_REJ  = 2'b11;

  function automatic logic [5:0] popcnt(input logic [34:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 35; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  state_t      state, state_nxt;
  logic        confirm_q;
  logic [34:0] map_q, shot_map_q, hit_map_q;
  logic [2:0]  row_q, col_q;
  logic [1:0]  cls_q, cls;
  logic [1:0]  status_q;
  logic        rv_q, win_q;
  logic [5:0]  hits_q, ship_q;
  logic [4:0]  shots_q;

  logic        fire, load_ok, accepted, is_hit, win_now, lim_now;
  logic [5:0]  idx, load_cnt, hits_nxt;
  logic [4:0]  shots_nxt;
  logic [63:0] map_ext, shot_ext;
  state_t      load_tgt;

  assign fire     = bus.confirm & ~confirm_q;
  assign load_ok  = bus.map_load && (state == S_EMPTY || state == S_READY || state == S_OVER);
  assign load_cnt = popcnt(bus.map_in);
  assign load_tgt = (load_cnt != 6'd0) ? S_READY : S_EMPTY;

  // Zero-extend so out-of-range indices from invalid coordinates read 0 safely
  assign map_ext  = {29'b0, map_q};
  assign shot_ext = {29'b0, shot_map_q};
  assign idx      = 6'(row_q) * 6'd5 + 6'(col_q);

  always_comb begin
    cls = ST_MISS;
    if (row_q > 3'd6 || col_q > 3'd4) cls = ST_REJ;
    else if (shot_ext[idx])           cls = ST_REJ;
    else if (map_ext[idx])            cls = ST_HIT;
  end

  assign accepted  = (cls_q != ST_REJ);
  assign is_hit    = (cls_q == ST_HIT);
  assign hits_nxt  = is_hit ? hits_q + 6'd1 : hits_q;
  assign shots_nxt = (accepted && shots_q != 5'd31) ? shots_q + 5'd1 : shots_q;
  assign win_now   = is_hit && (hits_nxt == ship_q);
`ifdef ATTACK_SHOT_LIMIT_EN
  assign lim_now   = accepted && (int'(shots_nxt) >= MAX_SHOTS);
`else
  assign lim_now   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY:  if (bus.map_load) state_nxt = load_tgt;
      S_READY:  begin
        if (bus.map_load) state_nxt = load_tgt;
        else if (fire)    state_nxt = S_CHECK;
      end
      S_CHECK:  state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = (win_now || lim_now) ? S_OVER : S_READY;
      S_OVER:   if (bus.map_load) state_nxt = load_tgt;
      default:  state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      confirm_q  <= 1'b0;
      map_q      <= '0;
      shot_map_q <= '0;
      hit_map_q  <= '0;
      row_q      <= '0;
      col_q      <= '0;
      cls_q      <= ST_NONE;
      status_q   <= ST_NONE;
      rv_q       <= 1'b0;
      win_q      <= 1'b0;
      hits_q     <= '0;
      ship_q     <= '0;
      shots_q    <= '0;
    end else begin
      confirm_q <= bus.confirm;
      rv_q      <= 1'b0;
      if (load_ok) begin
        map_q      <= bus.map_in;
        ship_q     <= load_cnt;
        shot_map_q <= '0;
        hit_map_q  <= '0;
        hits_q     <= '0;
        shots_q    <= '0;
        status_q   <= ST_NONE;
        win_q      <= 1'b0;
      end else begin
        case (state)
          S_READY: if (fire) begin
            row_q <= bus.row;
            col_q <= bus.col;
          end
          S_CHECK: cls_q <= cls;
          S_UPDATE: begin
            status_q <= cls_q;
            rv_q     <= 1'b1;
            hits_q   <= hits_nxt;
            shots_q  <= shots_nxt;
            win_q    <= win_now;
            if (accepted) shot_map_q[idx] <= 1'b1;
            if (is_hit)   hit_map_q[idx]  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.status       = status_q;
  assign bus.result_valid = rv_q;
  assign bus.hits         = hits_q;
  assign bus.shots        = shots_q;
  assign bus.ship_cells   = ship_q;
  assign bus.shot_map     = shot_map_q;
  assign bus.hit_map      = hit_map_q;
  assign bus.busy         = (state == S_CHECK) || (state == S_UPDATE);
  assign bus.game_over    = (state == S_OVER);
  assign bus.win          = win_q;

endmodule

// File: tb/tb_attack_resolver.sv
// Directed bench for attack_resolver: scoreboard of expected shot results checked on result_valid.
module tb_attack_resolver;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  attack_resolver_if bus ();
  attack_resolver #(.MAX_SHOTS(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [1:0] st; logic [5:0] h; logic [4:0] s; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int rv_cnt = 0;

  localparam logic [34:0] MAP = 35'h1 | (35'h1 << 34);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.result_valid === 1'b1) begin
      exp_t e;
      rv_cnt++;
      chk("sb_depth", 64'(sb.size()), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_status", bus.status, e.st);
        chk("sb_hits", bus.hits, e.h);
        chk("sb_shots", bus.shots, e.s);
      end
    end
  end

  task automatic load(input logic [34:0] m);
    bus.map_load = 1'b1;
    bus.map_in   = m;
    tick();
    bus.map_load = 1'b0;
  endtask

  task automatic fire(input logic [2:0] r, input logic [2:0] c, input bit exp_res,
                      input logic [1:0] st, input logic [5:0] h, input logic [4:0] s);
    int rv0;
    exp_t e;
    rv0 = rv_cnt;
    if (exp_res) begin
      e.st = st; e.h = h; e.s = s;
      sb.push_back(e);
    end
    bus.row = r;
    bus.col = c;
    bus.confirm = 1'b1;
    tick();
    chk("busy_n1", bus.busy, exp_res);
    bus.confirm = 1'b0;
    tick();
    chk("busy_n2", bus.busy, exp_res);
    tick();
    chk("busy_n3", bus.busy, 1'b0);
    tick();
    chk("rv_count", 64'(rv_cnt), 64'(rv0 + (exp_res ? 1 : 0)));
  endtask

  task automatic chk_reset_vals();
    chk("rst_status", bus.status, 2'b00);
    chk("rst_rv", bus.result_valid, 1'b0);
    chk("rst_hits", bus.hits, 6'd0);
    chk("rst_shots", bus.shots, 5'd0);
    chk("rst_ship_cells", bus.ship_cells, 6'd0);
    chk("rst_shot_map", bus.shot_map, 35'd0);
    chk("rst_hit_map", bus.hit_map, 35'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_game_over", bus.game_over, 1'b0);
    chk("rst_win", bus.win, 1'b0);
  endtask

  initial begin
    int rv0;
    rst = 1'b1;
    bus.map_load = 1'b0;
    bus.map_in = '0;
    bus.confirm = 1'b0;
    bus.row = '0;
    bus.col = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_reset_vals();

    // Empty map keeps the block idle
    load('0);
    chk("empty_ship_cells", bus.ship_cells, 6'd0);
    fire(3'd0, 3'd0, 1'b0, 2'b00, 6'd0, 5'd0);

    load(MAP);
    chk("load_ship_cells", bus.ship_cells, 6'd2);
    chk("load_status", bus.status, 2'b00);
    chk("load_game_over", bus.game_over, 1'b0);

    fire(3'd0, 3'd0, 1'b1, 2'b10, 6'd1, 5'd1);
    chk("hit_shot_map", bus.shot_map, 35'h1);
    chk("hit_hit_map", bus.hit_map, 35'h1);

    fire(3'd0, 3'd0, 1'b1, 2'b11, 6'd1, 5'd1);
    fire(3'd7, 3'd2, 1'b1, 2'b11, 6'd1, 5'd1);
    fire(3'd2, 3'd5, 1'b1, 2'b11, 6'd1, 5'd1);
    chk("rej_shot_map", bus.shot_map, 35'h1);
    chk("rej_hit_map", bus.hit_map, 35'h1);

    fire(3'd1, 3'd1, 1'b1, 2'b01, 6'd1, 5'd2);
    chk("miss_shot_map", bus.shot_map, 35'h1 | (35'h1 << 6));
    chk("miss_game_over", bus.game_over, 1'b0);

    // Third accepted shot completes the fleet: a win even at the shot limit
    fire(3'd6, 3'd4, 1'b1, 2'b10, 6'd2, 5'd3);
    chk("win_game_over", bus.game_over, 1'b1);
    chk("win_win", bus.win, 1'b1);
    chk("win_hit_map", bus.hit_map, MAP);
    chk("win_shot_map", bus.shot_map, MAP | (35'h1 << 6));

    fire(3'd0, 3'd1, 1'b0, 2'b00, 6'd0, 5'd0);
    chk("over_status", bus.status, 2'b10);
    chk("over_shots", bus.shots, 5'd3);

    load(MAP);
    chk("reload_game_over", bus.game_over, 1'b0);
    chk("reload_win", bus.win, 1'b0);
    chk("reload_shots", bus.shots, 5'd0);
    chk("reload_shot_map", bus.shot_map, 35'd0);
    chk("reload_status", bus.status, 2'b00);

`ifdef ATTACK_SHOT_LIMIT_EN
    fire(3'd1, 3'd0, 1'b1, 2'b01, 6'd0, 5'd1);
    fire(3'd1, 3'd1, 1'b1, 2'b01, 6'd0, 5'd2);
    chk("lim_not_over", bus.game_over, 1'b0);
    fire(3'd1, 3'd2, 1'b1, 2'b01, 6'd0, 5'd3);
    chk("lim_game_over", bus.game_over, 1'b1);
    chk("lim_win", bus.win, 1'b0);
    chk("lim_shots", bus.shots, 5'd3);
    load(MAP);
`else
    // Without a limit, a fourth accepted shot is allowed
    fire(3'd1, 3'd0, 1'b1, 2'b01, 6'd0, 5'd1);
    fire(3'd1, 3'd1, 1'b1, 2'b01, 6'd0, 5'd2);
    fire(3'd1, 3'd2, 1'b1, 2'b01, 6'd0, 5'd3);
    fire(3'd1, 3'd3, 1'b1, 2'b01, 6'd0, 5'd4);
    chk("nolim_game_over", bus.game_over, 1'b0);
    load(MAP);
`endif

    // Reset landing during UPDATE suppresses the result
    rv0 = rv_cnt;
    bus.row = 3'd0;
    bus.col = 3'd0;
    bus.confirm = 1'b1;
    tick();
    bus.confirm = 1'b0;
    tick();
    chk("mid_busy", bus.busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals();
    tick();
    tick();
    chk("mid_rv_none", 64'(rv_cnt), 64'(rv0));

    // Load and fire in the same READY cycle: load wins
    load(MAP);
    rv0 = rv_cnt;
    bus.map_load = 1'b1;
    bus.map_in = MAP;
    bus.confirm = 1'b1;
    tick();
    bus.map_load = 1'b0;
    bus.confirm = 1'b0;
    chk("both_busy", bus.busy, 1'b0);
    tick();
    tick();
    tick();
    chk("both_status", bus.status, 2'b00);
    chk("both_shots", bus.shots, 5'd0);
    chk("both_ship_cells", bus.ship_cells, 6'd2);
    chk("both_rv_none", 64'(rv_cnt), 64'(rv0));

    fire(3'd6, 3'd4, 1'b1, 2'b10, 6'd1, 5'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/attack_resolver.md
# attack_resolver

Game-state stage for the battleship board. Consumes the debounced confirm button and the attack coordinate switches, resolves each shot against the loaded 5×7 ship map, and keeps hit, shot and board-mark state. Its 2-bit status code feeds the status decoder/display mux downstream. Its shot and hit maps feed the LED matrix scanner.

## Interface
- `MAX_SHOTS`, default 20: valid shots allowed per game, range 1..31.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `map_load` input 1: one-cycle pulse that loads `map_in` and starts a new game.
- `map_in` input 35: ship map; bit `row*5+col` set means a ship cell.
- `confirm` input 1: debounced fire button, level signal.
- `row` input 3: attack row; valid values 0..6.
- `col` input 3: attack column; valid values 0..4.
- `status` output 2: last result. 00 = none, 01 = miss, 10 = hit, 11 = rejected (invalid or repeat).
- `result_valid` output 1: one-cycle pulse when `status` is updated.
- `hits` output 6: ship cells hit so far.
- `shots` output 5: accepted shots so far.
- `ship_cells` output 6: popcount of the loaded map.
- `shot_map` output 35: cells already fired on.
- `hit_map` output 35: cells fired on that held a ship.
- `busy` output 1: high while in CHECK or UPDATE.
- `game_over` output 1: game finished.
- `win` output 1: all ship cells hit; valid only while `game_over` is high.

## Operation
- Edge detect:
  - `confirm` is registered.
  - Fire event = `confirm` high and its previous sample low.
  - Fire events are honoured only in READY; in any other state they are dropped and not queued.
- States:
  - EMPTY: no map loaded.
  - READY
  - CHECK
  - UPDATE
  - OVER
- EMPTY:
  - `map_load` latches `map_in` and the popcount into `ship_cells`.
  - It clears `shot_map`, `hit_map`, `hits`, `shots` and `status`.
  - Goes to READY if popcount > 0, else stays in EMPTY.
- READY:
  - A fire event latches `row` and `col` and moves to CHECK.
  - `map_load` reloads the game exactly as in EMPTY.
- CHECK computes `idx = row*5+col` (6-bit) and classifies the shot:
  - `row > 6` or `col > 4`: invalid.
  - `shot_map[idx]` already set: repeat.
  - Otherwise a hit if `map[idx]` is set, else a miss.
  - Always moves to UPDATE.
- UPDATE:
  - Invalid or repeat: `status` = 11; no map or counter change.
  - Miss: set `shot_map[idx]`, increment `shots`, `status` = 01.
  - Hit: also set `hit_map[idx]`, increment `hits`, `status` = 10.
  - Pulses `result_valid`.
  - Next state is OVER if the new `hits` equals `ship_cells` (`win` = 1) or the shot limit is reached (`win` = 0); otherwise READY.
- OVER:
  - Maps, counters and `status` are frozen.
  - Only `map_load` leaves OVER; it reloads as in EMPTY.
- `map_load` in CHECK or UPDATE is ignored.
- A `map_load` and a fire event in the same READY cycle: the load wins and the fire event is discarded.
- Counters never wrap: `hits` is at most 35, and `shots` is at most `MAX_SHOTS` or saturates at 31.

## Timing
- Reset values:
  - State EMPTY, stored map = 0.
  - `status` = 00, `result_valid` = 0.
  - `hits`, `shots`, `ship_cells` = 0.
  - `shot_map`, `hit_map` = 0.
  - `busy`, `game_over`, `win` = 0.
- Latency, with the fire event detected in cycle N:
  - CHECK in N+1, UPDATE in N+2.
  - `status`, counters, maps and `result_valid` are visible in N+3.
  - `game_over` and `win` are visible in N+3.
  - `busy` is high in N+1 and N+2.
- Back-to-back throughput is one shot per 3 cycles. The real limit is the debounce rate.
- `map_load` takes effect the next cycle: `ship_cells` is valid and `status` is 00 in N+1.
- `rst` asserted in any state returns everything to the reset values on the next edge, including mid-CHECK or mid-UPDATE. The stored `confirm` sample also clears, so a button held through reset fires only after release and re-press.

## Configuration
- `ATTACK_SHOT_LIMIT_EN` defined:
  - Reaching `shots == MAX_SHOTS` on a non-winning UPDATE enters OVER with `win` = 0.
  - A hit that completes the fleet on the last allowed shot is a win.
- Not defined:
  - There is no shot limit; OVER is reached only by a win.
  - `shots` saturates at 31.
  - `MAX_SHOTS` is unused.

## Test plan
- Reset then load a map with cells 0 and 34 set → `ship_cells` = 2, state READY, all other outputs at reset values.
- Fire row 0, col 0 → three cycles later `status` = 10, `hits` = 1, `shots` = 1, `shot_map[0]` = `hit_map[0]` = 1, one `result_valid` pulse.
- Fire row 0, col 0 again, then row 7, col 2 → `status` = 11 both times, `shots` stays 1, maps unchanged.
- Fire row 1, col 1 → `status` = 01, `shot_map[6]` = 1, `hits` = 1. Then fire row 6, col 4 → `status` = 10, `hits` = 2, `game_over` = 1, `win` = 1. A further fire event is ignored.
- With `ATTACK_SHOT_LIMIT_EN` and `MAX_SHOTS` = 3, fire three misses on a 2-cell map → after the third, `game_over` = 1, `win` = 0, `shots` = 3.
- Fire event with `rst` asserted during UPDATE → no `result_valid`, all outputs at reset values, state EMPTY. Simultaneous `map_load` and fire event in READY → the game reloads and `status` stays 00.
